// File: rtl/vscale_mem_arbiter_pkg.sv
// Shared widths, owner encoding and request record for the instruction/data memory arbiter.
package vscale_mem_arbiter_pkg;

    localparam int unsigned XPR_LEN        = 32;
    localparam int unsigned MEM_TYPE_WIDTH = 3;

    // Fetches always move a full word.
    localparam logic [MEM_TYPE_WIDTH-1:0] MEM_TYPE_WORD = 3'd2;

    typedef enum logic [1:0] {
        ARB_OWNER_NONE = 2'd0,
        ARB_OWNER_IMEM = 2'd1,
        ARB_OWNER_DMEM = 2'd2
    } arb_owner_e;

    typedef struct packed {
        logic [XPR_LEN-1:0]        addr;
        logic                      wen;
        logic [MEM_TYPE_WIDTH-1:0] size;
    } dmem_req_t;

endpackage

// File: rtl/vscale_mem_arbiter_if.sv
// Pipeline imem/dmem ports plus the shared pipelined memory bus, as seen by the arbiter.
interface vscale_mem_arbiter_if;
    import vscale_mem_arbiter_pkg::*;

    logic [XPR_LEN-1:0]        imem_addr;
    logic                      imem_wait;
    logic [XPR_LEN-1:0]        imem_rdata;
    logic                      imem_badmem_e;

    logic                      dmem_en;
    logic                      dmem_wen;
    logic [MEM_TYPE_WIDTH-1:0] dmem_size;
    logic [XPR_LEN-1:0]        dmem_addr;
    logic [XPR_LEN-1:0]        dmem_wdata_delayed;
    logic                      dmem_wait;
    logic [XPR_LEN-1:0]        dmem_rdata;
    logic                      dmem_badmem_e;

    logic                      bus_req;
    logic [XPR_LEN-1:0]        bus_addr;
    logic                      bus_write;
    logic [MEM_TYPE_WIDTH-1:0] bus_size;
    logic [XPR_LEN-1:0]        bus_wdata;
    logic                      bus_ready;
    logic [XPR_LEN-1:0]        bus_rdata;
    logic                      bus_err;

    // Arbiter side.
    modport slave (
        input  imem_addr, dmem_en, dmem_wen, dmem_size, dmem_addr, dmem_wdata_delayed,
        input  bus_ready, bus_rdata, bus_err,
        output imem_wait, imem_rdata, imem_badmem_e,
        output dmem_wait, dmem_rdata, dmem_badmem_e,
        output bus_req, bus_addr, bus_write, bus_size, bus_wdata
    );

    // Pipeline plus memory side.
    modport master (
        output imem_addr, dmem_en, dmem_wen, dmem_size, dmem_addr, dmem_wdata_delayed,
        output bus_ready, bus_rdata, bus_err,
        input  imem_wait, imem_rdata, imem_badmem_e,
        input  dmem_wait, dmem_rdata, dmem_badmem_e,
        input  bus_req, bus_addr, bus_write, bus_size, bus_wdata
    );

endinterface

// File: rtl/vscale_mem_arbiter.sv
// Shares one address/data pipelined memory bus between fetch and the data port; data wins.
module vscale_mem_arbiter
    import vscale_mem_arbiter_pkg::*;
(
    input logic                  clk,
    input logic                  reset,
    vscale_mem_arbiter_if.slave  mem
);

    arb_owner_e owner_q, owner_d;
    logic       dw_q, dw_d;
    logic       pend_v_q, pend_v_d;
    dmem_req_t  pend_q, pend_d;

    dmem_req_t  dmem_req;
    dmem_req_t  sel_req;
    logic       sel_dmem;
    logic       accept;
    logic       dmem_wait;
    logic       dmem_sample;

    always_comb begin
        dmem_req    = '{addr: mem.dmem_addr, wen: mem.dmem_wen, size: mem.dmem_size};
        accept      = (owner_q == ARB_OWNER_NONE) || mem.bus_ready;
        dmem_wait   = pend_v_q || ((owner_q == ARB_OWNER_DMEM) && !mem.bus_ready);
        // A request held while stalled must not be sampled a second time.
        dmem_sample = mem.dmem_en && !dmem_wait;
        sel_dmem    = pend_v_q || dmem_sample;
        if (pend_v_q) begin
            sel_req = pend_q;
        end else if (dmem_sample) begin
            sel_req = dmem_req;
        end else begin
            sel_req = '{addr: mem.imem_addr, wen: 1'b0, size: MEM_TYPE_WORD};
        end
    end

    always_comb begin
        owner_d  = owner_q;
        dw_d     = dw_q;
        pend_v_d = pend_v_q;
        pend_d   = pend_q;
        if (accept) begin
            owner_d  = sel_dmem ? ARB_OWNER_DMEM : ARB_OWNER_IMEM;
            dw_d     = sel_dmem && sel_req.wen;
            pend_v_d = 1'b0;
        end else if (dmem_sample) begin
            pend_v_d = 1'b1;
            pend_d   = dmem_req;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            owner_q  <= ARB_OWNER_NONE;
            dw_q     <= 1'b0;
            pend_v_q <= 1'b0;
            pend_q   <= '0;
        end else begin
            owner_q  <= owner_d;
            dw_q     <= dw_d;
            pend_v_q <= pend_v_d;
            pend_q   <= pend_d;
        end
    end

    assign mem.bus_req   = !reset;
    assign mem.bus_addr  = sel_req.addr;
    assign mem.bus_write = sel_req.wen;
    assign mem.bus_size  = sel_req.size;
    assign mem.bus_wdata = ((owner_q == ARB_OWNER_DMEM) && dw_q) ? mem.dmem_wdata_delayed : '0;

    assign mem.dmem_wait     = dmem_wait;
    assign mem.imem_wait     = !((owner_q == ARB_OWNER_IMEM) && mem.bus_ready);
    assign mem.imem_rdata    = mem.bus_rdata;
    assign mem.dmem_rdata    = mem.bus_rdata;
    assign mem.imem_badmem_e = (owner_q == ARB_OWNER_IMEM) && mem.bus_ready && mem.bus_err;
    assign mem.dmem_badmem_e = (owner_q == ARB_OWNER_DMEM) && mem.bus_ready && mem.bus_err;

endmodule

// File: tb/tb_vscale_mem_arbiter.sv
// Directed plus random bench for vscale_mem_arbiter against a transaction-level reference model.
module tb_vscale_mem_arbiter;
    import vscale_mem_arbiter_pkg::*;

    logic clk;
    logic reset;

    vscale_mem_arbiter_if bus_if ();

    vscale_mem_arbiter dut (
        .clk   (clk),
        .reset (reset),
        .mem   (bus_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit valid;
        bit is_d;
        bit wr;
    } phase_t;

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;

    // Reference model: the data phase in flight and the sampled-but-unissued data requests.
    phase_t      ph;
    dmem_req_t   dq[$];
    int unsigned n_sampled = 0;
    int unsigned n_issued  = 0;
    int unsigned n_dropped = 0;

    logic [31:0] obs_addr;
    logic        obs_write;
    logic        obs_req;
    logic        obs_iwait;
    logic        obs_dwait;
    logic        obs_ibad;
    logic        obs_dbad;
    logic [31:0] obs_wdata;
    int unsigned n_issue_2000 = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // One clock: compare at the falling edge, advance the model at the rising edge.
    task automatic step();
        bit          acc, dwait, iwait, sampled, from_q, sel_d, fetch_go;
        dmem_req_t   req, sel;
        logic [31:0] exp_wdata;
        @(negedge clk);
        acc     = !ph.valid || bus_if.bus_ready;
        dwait   = (dq.size() != 0) || (ph.valid && ph.is_d && !bus_if.bus_ready);
        iwait   = !(ph.valid && !ph.is_d && bus_if.bus_ready);
        req     = '{addr: bus_if.dmem_addr, wen: bus_if.dmem_wen, size: bus_if.dmem_size};
        sampled = bus_if.dmem_en && !dwait;
        from_q  = dq.size() != 0;
        sel_d   = from_q || sampled;
        if (from_q) sel = dq[0];
        else if (sampled) sel = req;
        else sel = '{addr: bus_if.imem_addr, wen: 1'b0, size: MEM_TYPE_WORD};
        exp_wdata = (ph.valid && ph.is_d && ph.wr) ? bus_if.dmem_wdata_delayed : 32'h0;

        obs_addr  = bus_if.bus_addr;
        obs_write = bus_if.bus_write;
        obs_req   = bus_if.bus_req;
        obs_iwait = bus_if.imem_wait;
        obs_dwait = bus_if.dmem_wait;
        obs_ibad  = bus_if.imem_badmem_e;
        obs_dbad  = bus_if.dmem_badmem_e;
        obs_wdata = bus_if.bus_wdata;

        chk("bus_req", 32'(bus_if.bus_req), 32'(!reset));
        chk("dmem_wait", 32'(bus_if.dmem_wait), 32'(dwait));
        chk("imem_wait", 32'(bus_if.imem_wait), 32'(iwait));
        chk("imem_rdata", bus_if.imem_rdata, bus_if.bus_rdata);
        chk("dmem_rdata", bus_if.dmem_rdata, bus_if.bus_rdata);
        chk("imem_badmem", 32'(bus_if.imem_badmem_e),
            32'(ph.valid && !ph.is_d && bus_if.bus_ready && bus_if.bus_err));
        chk("dmem_badmem", 32'(bus_if.dmem_badmem_e),
            32'(ph.valid && ph.is_d && bus_if.bus_ready && bus_if.bus_err));
        chk("bus_wdata", bus_if.bus_wdata, exp_wdata);
        if (!reset && acc) begin
            chk("bus_addr", bus_if.bus_addr, sel.addr);
            chk("bus_write", 32'(bus_if.bus_write), 32'(sel.wen));
            chk("bus_size", 32'(bus_if.bus_size), 32'(sel.size));
            if (sel_d && sel.addr == 32'h2000 && sel.wen) n_issue_2000++;
        end

        fetch_go = 1'b0;
        @(posedge clk);
        if (reset) begin
            n_dropped += dq.size();
            dq.delete();
            ph = '{valid: 1'b0, is_d: 1'b0, wr: 1'b0};
        end else begin
            if (sampled) n_sampled++;
            if (acc) begin
                ph = '{valid: 1'b1, is_d: sel_d, wr: sel_d && sel.wen};
                if (from_q) void'(dq.pop_front());
                if (sel_d) n_issued++;
                else fetch_go = 1'b1;
            end else if (sampled) begin
                dq.push_back(req);
            end
        end
        #1;
        if (fetch_go) bus_if.imem_addr = bus_if.imem_addr + 32'd4;
        bus_if.bus_rdata          = $urandom;
        bus_if.dmem_wdata_delayed = (bus_if.dmem_wdata_delayed == 32'hDEADBEEF) ?
                                    32'hDEADBEEF : $urandom;
    endtask

    task automatic set_dmem(input bit en, input bit wen, input logic [31:0] addr);
        bus_if.dmem_en   = en;
        bus_if.dmem_wen  = wen;
        bus_if.dmem_addr = addr;
        bus_if.dmem_size = MEM_TYPE_WORD;
    endtask

    initial begin
        logic [31:0] held_imem;
        ph = '{valid: 1'b0, is_d: 1'b0, wr: 1'b0};
        reset = 1'b1;
        bus_if.imem_addr          = 32'h200;
        bus_if.dmem_wdata_delayed = 32'h0;
        bus_if.bus_ready          = 1'b1;
        bus_if.bus_rdata          = 32'h0;
        bus_if.bus_err            = 1'b0;
        set_dmem(1'b0, 1'b0, 32'h0);
        @(posedge clk);
        #1;

        // Reset state.
        step();
        chk("rst_bus_req", 32'(obs_req), 32'h0);
        chk("rst_imem_wait", 32'(obs_iwait), 32'h1);
        chk("rst_dmem_wait", 32'(obs_dwait), 32'h0);
        chk("rst_bus_wdata", obs_wdata, 32'h0);

        // Fetch stream.
        reset = 1'b0;
        step();
        chk("fetch0_addr", obs_addr, 32'h200);
        chk("fetch0_iwait", 32'(obs_iwait), 32'h1);
        step();
        chk("fetch1_addr", obs_addr, 32'h204);
        chk("fetch1_iwait", 32'(obs_iwait), 32'h0);
        step();
        chk("fetch2_addr", obs_addr, 32'h208);

        // Load collides with fetch of 0x20C.
        set_dmem(1'b1, 1'b0, 32'h1000);
        step();
        chk("coll_addr0", obs_addr, 32'h1000);
        chk("coll_dwait0", 32'(obs_dwait), 32'h0);
        set_dmem(1'b0, 1'b0, 32'h0);
        step();
        chk("coll_addr1", obs_addr, 32'h20C);
        chk("coll_dwait1", 32'(obs_dwait), 32'h0);
        chk("coll_iwait1", 32'(obs_iwait), 32'h1);
        step();
        chk("coll_iwait2", 32'(obs_iwait), 32'h0);

        // Store arrives while the fetch data phase stalls for two cycles.
        bus_if.bus_ready          = 1'b0;
        bus_if.dmem_wdata_delayed = 32'hDEADBEEF;
        set_dmem(1'b1, 1'b1, 32'h2000);
        step();
        chk("st_dwait0", 32'(obs_dwait), 32'h0);
        step();
        chk("st_dwait1", 32'(obs_dwait), 32'h1);
        bus_if.bus_ready = 1'b1;
        step();
        chk("st_issue_addr", obs_addr, 32'h2000);
        chk("st_issue_write", 32'(obs_write), 32'h1);
        chk("st_dwait2", 32'(obs_dwait), 32'h1);
        set_dmem(1'b0, 1'b0, 32'h0);
        step();
        chk("st_wdata", obs_wdata, 32'hDEADBEEF);
        chk("st_dwait3", 32'(obs_dwait), 32'h0);
        chk("st_issue_once", n_issue_2000, 32'd1);
        bus_if.dmem_wdata_delayed = 32'h0;

        // Bus error on a data phase.
        set_dmem(1'b1, 1'b0, 32'h3000);
        step();
        set_dmem(1'b0, 1'b0, 32'h0);
        bus_if.bus_err = 1'b1;
        step();
        chk("err_dbad", 32'(obs_dbad), 32'h1);
        chk("err_ibad", 32'(obs_ibad), 32'h0);
        bus_if.bus_err = 1'b0;
        step();
        chk("err_dbad_clear", 32'(obs_dbad), 32'h0);

        // Reset while a store sits pending behind a stalled fetch.
        bus_if.bus_ready = 1'b0;
        set_dmem(1'b1, 1'b1, 32'h4000);
        step();
        reset = 1'b1;
        step();
        chk("rstmid_bus_req0", 32'(obs_req), 32'h0);
        set_dmem(1'b0, 1'b0, 32'h0);
        step();
        chk("rstmid_bus_req1", 32'(obs_req), 32'h0);
        chk("rstmid_dwait", 32'(obs_dwait), 32'h0);
        chk("rstmid_iwait", 32'(obs_iwait), 32'h1);
        reset = 1'b0;
        bus_if.bus_ready = 1'b1;
        held_imem = bus_if.imem_addr;
        step();
        chk("rstmid_first_addr", obs_addr, held_imem);

        // Random soak.
        for (int i = 0; i < 3000; i++) begin
            bus_if.bus_ready = ($urandom_range(0, 3) != 0);
            bus_if.bus_err   = ($urandom_range(0, 7) == 0);
            bus_if.dmem_en   = ($urandom_range(0, 2) == 0);
            bus_if.dmem_wen  = $urandom_range(0, 1);
            bus_if.dmem_addr = {$urandom_range(0, 32'h3FFF), 2'b00};
            bus_if.dmem_size = 3'($urandom_range(0, 2));
            reset            = ($urandom_range(0, 499) == 0);
            step();
        end
        reset = 1'b0;
        set_dmem(1'b0, 1'b0, 32'h0);
        bus_if.bus_ready = 1'b1;
        step();
        step();
        chk("soak_all_issued", n_issued + n_dropped, n_sampled);
        chk("soak_queue_empty", dq.size(), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
